// File: rtl/fe_branch_predictor.sv
// Front-end branch predictor: gshare pattern table of 2-bit counters plus a
// direct-mapped BTB. Lookup is combinational for the fetch stage; updates are
// driven by resolutions coming back from AGEX, which also raise a one-cycle
// registered redirect pulse on a misprediction.
module fe_branch_predictor #(
    parameter int DBITS        = 32,
    parameter int PTINDEXBITS  = 8,
    parameter int BTBINDEXBITS = 4,
    parameter int BHRBITS      = 8    // must match PTINDEXBITS (XOR-folded index)
) (
    input  logic                    clk,
    input  logic                    reset,
    // fetch-side lookup
    input  logic                    fetch_valid,
    input  logic [DBITS-1:0]        fetch_pc,
    output logic                    pred_taken,
    output logic [DBITS-1:0]        pred_target,
    output logic [PTINDEXBITS-1:0]  pt_idx,
    output logic [BTBINDEXBITS-1:0] btb_idx,
    // AGEX resolution
    input  logic                    resolve_valid,
    input  logic                    resolve_is_jump,
    input  logic                    resolve_taken,
    input  logic [DBITS-1:0]        resolve_pc,
    input  logic [DBITS-1:0]        resolve_target,
    input  logic [PTINDEXBITS-1:0]  resolve_pt_idx,
    input  logic [BTBINDEXBITS-1:0] resolve_btb_idx,
    input  logic                    resolve_pred_taken,
    input  logic [DBITS-1:0]        resolve_pred_target,
    // redirect and statistics
    output logic                    mispredict,
    output logic [DBITS-1:0]        redirect_pc,
    output logic [DBITS-1:0]        branch_count,
    output logic [DBITS-1:0]        mispredict_count
);

    localparam int TAGBITS = DBITS - BTBINDEXBITS - 2;
    localparam int PT_N    = 1 << PTINDEXBITS;
    localparam int BTB_N   = 1 << BTBINDEXBITS;

    typedef struct packed {
        logic               valid;
        logic               is_jump;
        logic [TAGBITS-1:0] tag;
        logic [DBITS-1:0]   target;
    } btb_entry_t;

    logic [1:0]         pt  [PT_N];
    btb_entry_t         btb [BTB_N];
    logic [BHRBITS-1:0] bhr;
    btb_entry_t         fetch_entry;
    logic               btb_hit;
    logic               mis_now;

    // Combinational lookup; state written at the edge, so a same-cycle
    // update is not visible until the next cycle.
    always_comb begin
        pt_idx      = fetch_pc[PTINDEXBITS+1:2] ^ bhr;
        btb_idx     = fetch_pc[BTBINDEXBITS+1:2];
        fetch_entry = btb[btb_idx];
        btb_hit     = fetch_entry.valid && (fetch_entry.tag == fetch_pc[DBITS-1:BTBINDEXBITS+2]);
        pred_taken  = fetch_valid && btb_hit && (fetch_entry.is_jump || pt[pt_idx][1]);
        pred_target = pred_taken ? fetch_entry.target : fetch_pc + DBITS'(4);
    end

    // A wrong direction, or a wrong target on a taken instruction, is a miss.
    assign mis_now = resolve_valid &&
                     ((resolve_taken != resolve_pred_taken) ||
                      (resolve_taken && (resolve_target != resolve_pred_target)));

    // Pattern table and global history: trained only by conditional branches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PT_N; i++) pt[i] <= 2'b01;
            bhr <= '0;
        end else if (resolve_valid && !resolve_is_jump) begin
            if (resolve_taken) begin
                if (pt[resolve_pt_idx] != 2'b11) pt[resolve_pt_idx] <= pt[resolve_pt_idx] + 2'b01;
            end else begin
                if (pt[resolve_pt_idx] != 2'b00) pt[resolve_pt_idx] <= pt[resolve_pt_idx] - 2'b01;
            end
            bhr <= {bhr[BHRBITS-2:0], resolve_taken};
        end
    end

    // BTB: allocate/overwrite on every taken resolution, jumps included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_N; i++) btb[i] <= '0;
        end else if (resolve_valid && resolve_taken) begin
            btb[resolve_btb_idx] <= '{valid:   1'b1,
                                      is_jump: resolve_is_jump,
                                      tag:     resolve_pc[DBITS-1:BTBINDEXBITS+2],
                                      target:  resolve_target};
        end
    end

    // Registered redirect pulse; redirect_pc keeps its last value between misses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= mis_now;
            if (mis_now) redirect_pc <= resolve_taken ? resolve_target : resolve_pc + DBITS'(4);
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve_valid && (branch_count != '1)) branch_count <= branch_count + DBITS'(1);
            if (mis_now && (mispredict_count != '1)) mispredict_count <= mispredict_count + DBITS'(1);
        end
    end

endmodule

// File: tb/tb_fe_branch_predictor.sv
// Bench for fe_branch_predictor: directed resolve/fetch sequences, a
// behavioural predictor model compared every cycle, and literal pins.
module tb_fe_branch_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pt_idx;
    logic [3:0]  btb_idx;
    logic        resolve_valid = 1'b0, resolve_is_jump = 1'b0, resolve_taken = 1'b0;
    logic [31:0] resolve_pc = '0, resolve_target = '0;
    logic [7:0]  resolve_pt_idx = '0;
    logic [3:0]  resolve_btb_idx = '0;
    logic        resolve_pred_taken = 1'b0;
    logic [31:0] resolve_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc, branch_count, mispredict_count;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    fe_branch_predictor dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .pt_idx(pt_idx), .btb_idx(btb_idx),
        .resolve_valid(resolve_valid), .resolve_is_jump(resolve_is_jump),
        .resolve_taken(resolve_taken), .resolve_pc(resolve_pc),
        .resolve_target(resolve_target), .resolve_pt_idx(resolve_pt_idx),
        .resolve_btb_idx(resolve_btb_idx), .resolve_pred_taken(resolve_pred_taken),
        .resolve_pred_target(resolve_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_pt [256];          // counter strength 0..3
    bit          m_bv [16];
    bit          m_bj [16];
    logic [31:0] m_btag [16];         // pc >> 6
    logic [31:0] m_btgt [16];
    int          m_bhr;               // last 8 branch outcomes, newest in bit 0
    bit          m_mis;
    logic [31:0] m_redir;
    int          m_bc, m_mc;

    function automatic bit wrong_guess();
        if (!resolve_valid) return 1'b0;
        if (resolve_taken != resolve_pred_taken) return 1'b1;
        return resolve_taken && (resolve_target != resolve_pred_target);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) m_pt[i] <= 1;
            for (int i = 0; i < 16; i++) m_bv[i] <= 1'b0;
            m_bhr <= 0; m_mis <= 1'b0; m_redir <= '0; m_bc <= 0; m_mc <= 0;
        end else begin
            m_mis <= wrong_guess();
            if (wrong_guess()) begin
                m_mc    <= m_mc + 1;
                m_redir <= resolve_taken ? resolve_target : resolve_pc + 32'd4;
            end
            if (resolve_valid) begin
                m_bc <= m_bc + 1;
                if (!resolve_is_jump) begin
                    m_pt[resolve_pt_idx] <= resolve_taken ? ((m_pt[resolve_pt_idx] + 1 > 3) ? 3 : m_pt[resolve_pt_idx] + 1)
                                                          : ((m_pt[resolve_pt_idx] - 1 < 0) ? 0 : m_pt[resolve_pt_idx] - 1);
                    m_bhr <= (m_bhr * 2 + int'(resolve_taken)) % 256;
                end
                if (resolve_taken) begin
                    m_bv[resolve_btb_idx]   <= 1'b1;
                    m_bj[resolve_btb_idx]   <= resolve_is_jump;
                    m_btag[resolve_btb_idx] <= resolve_pc >> 6;
                    m_btgt[resolve_btb_idx] <= resolve_target;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int pi, bi;
            bit hit, tk;
            pi  = ((fetch_pc >> 2) % 256) ^ m_bhr;
            bi  = (fetch_pc >> 2) % 16;
            hit = m_bv[bi] && (m_btag[bi] == (fetch_pc >> 6));
            tk  = fetch_valid && hit && (m_bj[bi] || m_pt[pi] >= 2);
            check("m_pt_idx", 32'(pt_idx), 32'(pi));
            check("m_btb_idx", 32'(btb_idx), 32'(bi));
            check("m_pred_taken", 32'(pred_taken), 32'(tk));
            check("m_pred_target", pred_target, tk ? m_btgt[bi] : fetch_pc + 32'd4);
            check("m_mispredict", 32'(mispredict), 32'(m_mis));
            check("m_redirect_pc", redirect_pc, m_redir);
            check("m_branch_count", branch_count, 32'(m_bc));
            check("m_mispredict_count", mispredict_count, 32'(m_mc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic rs(input bit j, input bit t, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic [7:0] pi, input logic [3:0] bi, input bit pt, input logic [31:0] ptg);
        resolve_valid = 1'b1; resolve_is_jump = j; resolve_taken = t;
        resolve_pc = pc; resolve_target = tgt; resolve_pt_idx = pi; resolve_btb_idx = bi;
        resolve_pred_taken = pt; resolve_pred_target = ptg;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        resolve_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        // reset state
        check("rst_mispredict", 32'(mispredict), 32'd0);
        check("rst_redirect", redirect_pc, 32'd0);
        check("rst_bc", branch_count, 32'd0);
        check("rst_mc", mispredict_count, 32'd0);

        // cold lookup
        fetch_valid = 1'b1; fetch_pc = 32'h100; #1;
        check("cold_taken", 32'(pred_taken), 32'd0);
        check("cold_target", pred_target, 32'h104);
        check("cold_pt_idx", 32'(pt_idx), 32'h40);
        check("cold_btb_idx", 32'(btb_idx), 32'h0);

        // first taken branch, predicted not taken
        rs(0, 1, 32'h100, 32'h80, 8'h40, 4'h0, 0, 32'h104); tick();
        check("b1_mis", 32'(mispredict), 32'd1);
        check("b1_redirect", redirect_pc, 32'h80);
        check("b1_mc", mispredict_count, 32'd1);
        check("b1_bhr_idx", 32'(pt_idx), 32'h41);
        tick();
        check("b1_pulse_end", 32'(mispredict), 32'd0);
        check("b1_redirect_hold", redirect_pc, 32'h80);

        // JAL: BTB only, no history change
        fetch_pc = 32'h200;
        rs(1, 1, 32'h200, 32'h400, 8'h81, 4'h0, 0, 32'h204); #1;
        check("jal_preupdate", 32'(pred_taken), 32'd0);
        tick();
        check("jal_taken", 32'(pred_taken), 32'd1);
        check("jal_target", pred_target, 32'h400);
        check("jal_pt_idx", 32'(pt_idx), 32'h81);

        // four taken on one entry, back-to-back misses
        fetch_pc = 32'h104;
        for (int k = 0; k < 4; k++) begin rs(0, 1, 32'h104, 32'h300, 8'h5E, 4'h1, 0, 32'h108); tick(); end
        check("sat3_pt_idx", 32'(pt_idx), 32'h5E);
        check("sat3_taken", 32'(pred_taken), 32'd1);
        check("sat3_target", pred_target, 32'h300);
        check("sat3_bc", branch_count, 32'd6);
        check("sat3_mc", mispredict_count, 32'd6);

        // charge another entry to 3, then four not-taken drive it to 0
        for (int k = 0; k < 2; k++) begin rs(0, 1, 32'h104, 32'h300, 8'hB1, 4'h1, 1, 32'h300); tick(); end
        for (int k = 0; k < 4; k++) begin rs(0, 0, 32'h104, 32'h300, 8'hB1, 4'h1, 1, 32'h300); tick(); end
        check("sat0_pt_idx", 32'(pt_idx), 32'hB1);
        check("sat0_taken", 32'(pred_taken), 32'd0);
        check("sat0_target", pred_target, 32'h108);
        check("sat0_mc", mispredict_count, 32'd10);

        // correctly predicted taken
        rs(0, 1, 32'h104, 32'h300, 8'hB1, 4'h1, 1, 32'h300); tick();
        check("ok_mis", 32'(mispredict), 32'd0);
        check("ok_bc", branch_count, 32'd13);
        check("ok_mc", mispredict_count, 32'd10);

        // right direction, wrong target
        rs(0, 1, 32'h104, 32'h340, 8'hB1, 4'h1, 1, 32'h300); tick();
        check("tgt_mis", 32'(mispredict), 32'd1);
        check("tgt_redirect", redirect_pc, 32'h340);

        // not-taken redirect wraps pc+4
        rs(0, 0, 32'hFFFF_FFFC, 32'h0, 8'h00, 4'hF, 1, 32'h10); tick();
        check("wrap_redirect", redirect_pc, 32'h0);
        check("wrap_mc", mispredict_count, 32'd12);

        // fetch_valid gating and fetch pc+4 wrap
        fetch_valid = 1'b0; fetch_pc = 32'h200; #1;
        check("nofetch_taken", 32'(pred_taken), 32'd0);
        check("nofetch_target", pred_target, 32'h204);
        fetch_valid = 1'b1; #1;
        check("jump_any_ctr", pred_target, 32'h400);
        fetch_pc = 32'hFFFF_FFFC; #1;
        check("fetch_wrap", pred_target, 32'h0);
        fetch_pc = 32'h200;

        // reset one cycle after a mispredicting resolve
        rs(0, 1, 32'h100, 32'h80, 8'h40, 4'h0, 0, 32'h104); tick();
        check("pre_rst_mis", 32'(mispredict), 32'd1);
        reset = 1'b0; #1;
        check("rst2_mis", 32'(mispredict), 32'd0);
        check("rst2_redirect", redirect_pc, 32'd0);
        check("rst2_bc", branch_count, 32'd0);
        check("rst2_mc", mispredict_count, 32'd0);
        check("rst2_btb", 32'(pred_taken), 32'd0);
        check("rst2_pt_idx", 32'(pt_idx), 32'h80);

        // resolve during reset is dropped
        rs(0, 1, 32'h200, 32'h500, 8'h80, 4'h0, 0, 32'h204);
        @(posedge clk); #1;
        check("rst_drop_bc", branch_count, 32'd0);
        check("rst_drop_mis", 32'(mispredict), 32'd0);
        resolve_valid = 1'b0; reset = 1'b1; #1;
        check("rst_drop_pt_idx", 32'(pt_idx), 32'h80);

        // first update after release
        rs(0, 1, 32'h200, 32'h500, 8'h80, 4'h0, 0, 32'h204); tick();
        check("post_rst_mis", 32'(mispredict), 32'd1);
        check("post_rst_redirect", redirect_pc, 32'h500);
        check("post_rst_bc", branch_count, 32'd1);
        check("post_rst_pt_idx", 32'(pt_idx), 32'h81);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fe_branch_predictor.md
FE_BRANCH_PREDICTOR -- requirements
Module: fe_branch_predictor

Interface
REQ-001 Parameter DBITS, default 32, data/PC width.
REQ-002 Parameter PTINDEXBITS, default 8, pattern-table index width (256 entries).
REQ-003 Parameter BTBINDEXBITS, default 4, branch-target-buffer index width (16 entries).
REQ-004 Parameter BHRBITS, default 8, branch-history register width; SHALL equal PTINDEXBITS.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-007 fetch_valid  input  1  fetch requests a prediction this cycle.
REQ-008 fetch_pc  input  DBITS  PC being fetched.
REQ-009 pred_taken  output  1  predicted taken for fetch_pc.
REQ-010 pred_target  output  DBITS  predicted next PC.
REQ-011 pt_idx  output  PTINDEXBITS  PT index used, carried down the pipe to AGEX.
REQ-012 btb_idx  output  BTBINDEXBITS  BTB index used, carried down the pipe to AGEX.
REQ-013 resolve_valid  input  1  AGEX resolved a control-flow instruction this cycle.
REQ-014 resolve_is_jump  input  1  1 = JAL/JALR, 0 = conditional branch.
REQ-015 resolve_taken  input  1  AGEX br_cond.
REQ-016 resolve_pc / resolve_target  input  DBITS each  instruction PC; AGEX newpc.
REQ-017 resolve_pt_idx / resolve_btb_idx  input  PTINDEXBITS / BTBINDEXBITS  indices returned from AGEX.
REQ-018 resolve_pred_taken / resolve_pred_target  input  1 / DBITS  prediction originally made.
REQ-019 mispredict  output  1  registered one-cycle redirect pulse.
REQ-020 redirect_pc  output  DBITS  correct next PC, valid while mispredict=1.
REQ-021 branch_count / mispredict_count  output  DBITS each  statistics counters.

Function
REQ-022 pt_idx SHALL be fetch_pc[PTINDEXBITS+1:2] XOR bhr; btb_idx SHALL be fetch_pc[BTBINDEXBITS+1:2]; tag SHALL be fetch_pc[DBITS-1:BTBINDEXBITS+2].
REQ-023 PT entries SHALL be 2-bit saturating counters; BTB entries SHALL hold {valid, is_jump, tag, target}.
REQ-024 Lookup SHALL be combinational, same cycle: btb_hit = valid AND tag match; pred_taken = btb_hit AND (is_jump OR counter[1]); pred_target = pred_taken ? BTB target : fetch_pc+4.
REQ-025 With fetch_valid=0, pred_taken SHALL be 0 and pred_target fetch_pc+4.
REQ-026 On resolve_valid with resolve_is_jump=0: counter at resolve_pt_idx SHALL increment (taken) or decrement (not taken), saturating at 3 and 0; bhr SHALL become {bhr[BHRBITS-2:0], resolve_taken}.
REQ-027 Jumps SHALL NOT modify PT or bhr.
REQ-028 On resolve_valid with resolve_taken=1, BTB[resolve_btb_idx] SHALL be written {1, resolve_is_jump, tag(resolve_pc), resolve_target}; not-taken resolution SHALL leave the BTB unchanged.
REQ-029 Misprediction = resolve_valid AND (resolve_taken != resolve_pred_taken OR (resolve_taken AND resolve_target != resolve_pred_target)).
REQ-030 mispredict SHALL assert exactly the cycle after the resolving edge for one cycle; redirect_pc = resolve_taken ? resolve_target : resolve_pc+4; redirect_pc SHALL hold its last value otherwise.
REQ-031 Back-to-back resolves SHALL each produce independent pulses; no resolve is dropped.
REQ-032 Same-cycle lookup and update of one entry: lookup SHALL return the pre-update value; update lands at the edge.
REQ-033 branch_count SHALL increment per resolve_valid; mispredict_count per misprediction; both saturate at all-ones.
REQ-034 PC+4 arithmetic SHALL wrap modulo 2^DBITS.

Reset
REQ-035 While reset=0, asynchronously: all PT counters = 2'b01, all BTB valid = 0, bhr = 0, mispredict = 0, redirect_pc = 0, both counters = 0.
REQ-036 A resolve coincident with reset assertion SHALL be discarded; a pending mispredict pulse SHALL be cancelled.
REQ-037 First update SHALL occur on the first rising edge with reset=1 and resolve_valid=1.

Verification
REQ-038 After reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0x104, pt_idx=0x40, btb_idx=0x0.
REQ-039 Resolve branch pc=0x100 taken target=0x80 pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x80; BTB[0] valid, counter 01->10, bhr=0x01, mispredict_count=1.
REQ-040 Resolve JAL pc=0x200 target=0x400, then fetch 0x200 -> pred_taken=1, pred_target=0x400, no PT/bhr change.
REQ-041 Four taken resolves on one PT entry -> counter saturates at 3; four not-taken -> saturates at 0, pred_taken=0 on hit.
REQ-042 Resolve correctly predicted taken (target matches) -> mispredict stays 0, branch_count increments, mispredict_count unchanged.
REQ-043 Assert reset one cycle after a mispredicting resolve -> mispredict=0 immediately, BTB valid bits cleared, counters 0.
